// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus controller: register map, IIR codes,
// LCR/LSR bit positions and the bus FSM state type.
package uart_pkg;

  localparam logic [2:0] ADDR_THR   = 3'd0;
  localparam logic [2:0] ADDR_RBR   = 3'd0;
  localparam logic [2:0] ADDR_IER   = 3'd1;
  localparam logic [2:0] ADDR_IIR   = 3'd2;
  localparam logic [2:0] ADDR_LCR   = 3'd3;
  localparam logic [2:0] ADDR_LSR   = 3'd4;
  localparam logic [2:0] ADDR_BAUD0 = 3'd5;
  localparam logic [2:0] ADDR_BAUD1 = 3'd6;
  localparam logic [2:0] ADDR_BAUD2 = 3'd7;

  localparam logic [2:0] IIR_ERR  = 3'b110;
  localparam logic [2:0] IIR_RX   = 3'b100;
  localparam logic [2:0] IIR_TX   = 3'b010;
  localparam logic [2:0] IIR_NONE = 3'b001;

  localparam int unsigned IER_RX  = 0;
  localparam int unsigned IER_TX  = 1;
  localparam int unsigned IER_ERR = 2;

  localparam int unsigned LCR_CHECK    = 4;
  localparam int unsigned LCR_PARITY   = 5;
  localparam int unsigned LCR_ST_CHECK = 6;
  localparam logic [6:0]  LCR_RST      = 7'h08;

  localparam int unsigned LSR_RX_AVAIL = 0;
  localparam int unsigned LSR_P_ERR    = 1;
  localparam int unsigned LSR_ST_ERR   = 2;
  localparam int unsigned LSR_TX_FULL  = 3;
  localparam int unsigned LSR_TX_IDLE  = 4;
  localparam int unsigned LSR_RX_WORK  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_THR,
    ST_RD_POP,
    ST_RD_WAIT,
    ST_DONE
  } bus_state_e;

endpackage

// File: rtl/uart_bus_ctrl_if.sv
// Simple 8-bit synchronous CPU bus: cs held until the one-cycle ready strobe.
interface uart_bus_ctrl_if;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ready;

  modport master (output cs, we, addr, wdata, input rdata, ready);
  modport slave  (input cs, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/uart_irq_ctrl.sv
// Tx-empty event flag, prioritised IIR encode and registered interrupt line.
module uart_irq_ctrl
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] ier,
  input  logic       p_error,
  input  logic       st_error,
  input  logic       rx_fifo_empty,
  input  logic       tx_idle,
  input  logic       iir_clr,
  input  logic       thr_wr,
  output logic [2:0] iir,
  output logic       irq
);

  logic flag_q, flag_d;
  logic tx_idle_q, tx_idle_d;
  logic ier_tx_q, ier_tx_d;
  logic irq_q, irq_d;
  logic flag_set;

  always_comb begin
    flag_set  = (tx_idle && !tx_idle_q) || (ier[IER_TX] && !ier_tx_q && tx_idle);
    flag_d    = flag_q;
    // clearing takes precedence over a coincident set
    if (iir_clr || thr_wr) flag_d = 1'b0;
    else if (flag_set)     flag_d = 1'b1;
    tx_idle_d = tx_idle;
    ier_tx_d  = ier[IER_TX];

    iir = IIR_NONE;
    if ((p_error || st_error) && ier[IER_ERR]) iir = IIR_ERR;
    else if (!rx_fifo_empty && ier[IER_RX])    iir = IIR_RX;
    else if (flag_q && ier[IER_TX])            iir = IIR_TX;
    irq_d = (iir != IIR_NONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flag_q    <= 1'b0;
      tx_idle_q <= 1'b1;
      ier_tx_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      flag_q    <= flag_d;
      tx_idle_q <= tx_idle_d;
      ier_tx_q  <= ier_tx_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/uart_bus_ctrl.sv
// CPU register front end for UART_TOP: bus FSM, staged line/baud config,
// FIFO push/pop and error-ack pulses, and the interrupt controller.
module uart_bus_ctrl
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ     = 50_000_000,
  parameter int unsigned DEFAULT_BAUD = 115200,
  parameter int unsigned FIFO_RD_LAT  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  uart_bus_ctrl_if.slave        bus,
  output logic                  irq,
  output logic [19:0]           uart_buad,
  output logic [3:0]            data_length,
  output logic                  check,
  output logic                  st_check,
  output logic                  parity,
  output logic [7:0]            tx_in_data,
  output logic                  tx_fifo_write,
  output logic                  rx_fifo_read,
  output logic                  p_error_ack,
  output logic                  st_error_ack,
  input  logic                  st_error,
  input  logic                  p_error,
  input  logic                  rx_fifo_empty,
  input  logic                  rx_work,
  input  logic                  tx_fifo_full,
  input  logic                  tx_work,
  input  logic [4:0]            rx_fifo_cnt,
  input  logic [4:0]            tx_fifo_cnt,
  input  logic [7:0]            data_to_reg
);

  localparam logic [19:0] BAUD_RST = 20'(DEFAULT_BAUD);
  localparam logic [1:0]  LAT_LAST = 2'(FIFO_RD_LAT - 1);

  if (FIFO_RD_LAT < 1 || FIFO_RD_LAT > 3 || CLK_FREQ <= 0) begin : g_bad_param
    $error("uart_bus_ctrl: FIFO_RD_LAT must be 1..3 and CLK_FREQ positive");
  end

  bus_state_e  state_q, state_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        p_ack_q, p_ack_d;
  logic        st_ack_q, st_ack_d;
  logic [2:0]  ier_q, ier_d;
  logic [6:0]  lcr_sh_q, lcr_sh_d;
  logic [19:0] baud_sh_q, baud_sh_d;
  logic [6:0]  lcr_q, lcr_d;
  logic [19:0] baud_q, baud_d;
  logic        commit_q, commit_d;

  logic        tx_idle;
  logic [7:0]  lsr;
  logic [7:0]  reg_rd;
  logic [2:0]  iir;
  logic        accept;
  logic        iir_clr;
  logic        thr_wr;
  logic        unused_ok;

  assign unused_ok = ^rx_fifo_cnt;
  assign tx_idle   = (tx_fifo_cnt == 5'd0) && !tx_work;
  assign accept    = (state_q == ST_IDLE) && bus.cs;
  assign thr_wr    = accept && bus.we && (bus.addr == ADDR_THR);
  assign iir_clr   = accept && !bus.we && (bus.addr == ADDR_IIR) && (iir == IIR_TX);

  always_comb begin
    lsr               = '0;
    lsr[LSR_RX_AVAIL] = !rx_fifo_empty;
    lsr[LSR_P_ERR]    = p_error;
    lsr[LSR_ST_ERR]   = st_error;
    lsr[LSR_TX_FULL]  = tx_fifo_full;
    lsr[LSR_TX_IDLE]  = tx_idle;
    lsr[LSR_RX_WORK]  = rx_work;

    reg_rd = '0;
    case (bus.addr)
      ADDR_IER:   reg_rd = {5'b0, ier_q};
      ADDR_IIR:   reg_rd = {5'b0, iir};
      ADDR_LCR:   reg_rd = {1'b0, lcr_sh_q};
      ADDR_LSR:   reg_rd = lsr;
      ADDR_BAUD0: reg_rd = baud_sh_q[7:0];
      ADDR_BAUD1: reg_rd = baud_sh_q[15:8];
      ADDR_BAUD2: reg_rd = {4'b0, baud_sh_q[19:16]};
      default:    reg_rd = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    rdata_d   = rdata_q;
    tx_data_d = tx_data_q;
    p_ack_d   = 1'b0;
    st_ack_d  = 1'b0;
    ier_d     = ier_q;
    lcr_sh_d  = lcr_sh_q;
    baud_sh_d = baud_sh_q;
    lcr_d     = lcr_q;
    baud_d    = baud_q;
    commit_d  = commit_q;

    // commit uses the pre-write shadows; a write in the same cycle re-arms it below
    if (commit_q && !tx_work && !rx_work) begin
      lcr_d    = lcr_sh_q;
      baud_d   = baud_sh_q;
      commit_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.cs) begin
          state_d = ST_DONE;
          if (bus.we) begin
            case (bus.addr)
              ADDR_THR: begin
                tx_data_d = bus.wdata;
                state_d   = ST_WR_THR;
              end
              ADDR_IER:   ier_d = bus.wdata[2:0];
              ADDR_LCR: begin
                lcr_sh_d = bus.wdata[6:0];
                commit_d = 1'b1;
              end
              ADDR_BAUD0: baud_sh_d[7:0]   = bus.wdata;
              ADDR_BAUD1: baud_sh_d[15:8]  = bus.wdata;
              ADDR_BAUD2: begin
                baud_sh_d[19:16] = bus.wdata[3:0];
                commit_d         = 1'b1;
              end
              default: ;
            endcase
          end else if (bus.addr == ADDR_RBR) begin
            if (rx_fifo_empty) rdata_d = '0;
            else               state_d = ST_RD_POP;
          end else begin
            rdata_d = reg_rd;
            if (bus.addr == ADDR_LSR) begin
              p_ack_d  = p_error;
              st_ack_d = st_error;
            end
          end
        end
      end
      ST_WR_THR: if (!tx_fifo_full) state_d = ST_DONE;
      ST_RD_POP: begin
        lat_cnt_d = '0;
        state_d   = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          rdata_d = data_to_reg;
          state_d = ST_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      rdata_q   <= '0;
      tx_data_q <= '0;
      p_ack_q   <= 1'b0;
      st_ack_q  <= 1'b0;
      ier_q     <= '0;
      lcr_sh_q  <= LCR_RST;
      baud_sh_q <= BAUD_RST;
      lcr_q     <= LCR_RST;
      baud_q    <= BAUD_RST;
      commit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      rdata_q   <= rdata_d;
      tx_data_q <= tx_data_d;
      p_ack_q   <= p_ack_d;
      st_ack_q  <= st_ack_d;
      ier_q     <= ier_d;
      lcr_sh_q  <= lcr_sh_d;
      baud_sh_q <= baud_sh_d;
      lcr_q     <= lcr_d;
      baud_q    <= baud_d;
      commit_q  <= commit_d;
    end
  end

  uart_irq_ctrl u_irq (
    .clk           (clk),
    .rstn          (rstn),
    .ier           (ier_q),
    .p_error       (p_error),
    .st_error      (st_error),
    .rx_fifo_empty (rx_fifo_empty),
    .tx_idle       (tx_idle),
    .iir_clr       (iir_clr),
    .thr_wr        (thr_wr),
    .iir           (iir),
    .irq           (irq)
  );

  assign bus.rdata     = rdata_q;
  assign bus.ready     = (state_q == ST_DONE);
  assign tx_fifo_write = (state_q == ST_WR_THR) && !tx_fifo_full;
  assign rx_fifo_read  = (state_q == ST_RD_POP);
  assign tx_in_data    = tx_data_q;
  assign p_error_ack   = p_ack_q;
  assign st_error_ack  = st_ack_q;
  assign uart_buad     = baud_q;
  assign data_length   = lcr_q[3:0];
  assign check         = lcr_q[LCR_CHECK];
  assign parity        = lcr_q[LCR_PARITY];
  assign st_check      = lcr_q[LCR_ST_CHECK];

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Scoreboard bench for uart_bus_ctrl: read expectations are queued when the
// access is issued and checked by a monitor when ready appears.
module tb_uart_bus_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        irq;
  logic [19:0] uart_buad;
  logic [3:0]  data_length;
  logic        check, st_check, parity;
  logic [7:0]  tx_in_data;
  logic        tx_fifo_write, rx_fifo_read, p_error_ack, st_error_ack;
  logic        st_error = 0, p_error = 0, rx_fifo_empty = 1, rx_work = 0;
  logic        tx_fifo_full = 0, tx_work = 0;
  logic [4:0]  rx_fifo_cnt = 0, tx_fifo_cnt = 0;
  logic [7:0]  data_to_reg = 0;

  uart_bus_ctrl_if bus ();

  uart_bus_ctrl #(.CLK_FREQ(50_000_000), .DEFAULT_BAUD(115200), .FIFO_RD_LAT(2)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .irq(irq), .uart_buad(uart_buad),
    .data_length(data_length), .check(check), .st_check(st_check), .parity(parity),
    .tx_in_data(tx_in_data), .tx_fifo_write(tx_fifo_write), .rx_fifo_read(rx_fifo_read),
    .p_error_ack(p_error_ack), .st_error_ack(st_error_ack), .st_error(st_error),
    .p_error(p_error), .rx_fifo_empty(rx_fifo_empty), .rx_work(rx_work),
    .tx_fifo_full(tx_fifo_full), .tx_work(tx_work), .rx_fifo_cnt(rx_fifo_cnt),
    .tx_fifo_cnt(tx_fifo_cnt), .data_to_reg(data_to_reg)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned n_cmp = 0, n_err = 0;
  int unsigned wr_cnt = 0, rd_cnt = 0, pack_cnt = 0, sack_cnt = 0;
  int unsigned wr_cyc = 0, rdy_cyc = 0;
  logic [7:0]  wr_data = 0;
  logic [7:0]  exp_q[$];
  string       tag_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_fifo_write) begin wr_cnt++; wr_cyc = cyc; wr_data = tx_in_data; end
    if (rx_fifo_read) rd_cnt++;
    if (p_error_ack) pack_cnt++;
    if (st_error_ack) sack_cnt++;
    if (bus.ready) begin
      rdy_cyc = cyc;
      if (!bus.we) begin
        if (exp_q.size() == 0) check_val("unexpected_read", 32'(bus.rdata), 32'hFFFF_FFFF);
        else check_val(tag_q.pop_front(), 32'(bus.rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic bus_access(input logic w, input logic [2:0] a, input logic [7:0] d,
                            output int unsigned lat);
    int unsigned start;
    bit seen = 0;
    @(posedge clk); #1;
    bus.cs = 1; bus.we = w; bus.addr = a; bus.wdata = d;
    start = cyc;
    lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.ready) begin seen = 1; lat = cyc - start; end
    end
    if (!seen) check_val("ready_timeout", 32'(a), 32'hDEAD);
    @(posedge clk); #1;
    bus.cs = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    int unsigned lat;
    bus_access(1'b1, a, d, lat);
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [7:0] exp,
                    output int unsigned lat);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus_access(1'b0, a, 8'h00, lat);
  endtask

  task automatic wait_irq(input string tag, input logic lvl);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (irq === lvl) seen = 1;
    end
    check_val(tag, 32'(irq), 32'(lvl));
  endtask

  initial begin
    int unsigned lat;
    bus.cs = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_ready", 32'(bus.ready), 32'd0);
    check_val("rst_rdata", 32'(bus.rdata), 32'd0);
    check_val("rst_baud", 32'(uart_buad), 32'd115200);
    check_val("rst_dlen", 32'(data_length), 32'd8);
    check_val("rst_cfg", 32'({check, parity, st_check}), 32'd0);

    // register defaults through the bus
    rd("lcr_rst", 3'd3, 8'h08, lat);
    check_val("reg_latency", lat, 1);
    rd("baud0_rst", 3'd5, 8'h00, lat);
    rd("baud1_rst", 3'd6, 8'hC2, lat);
    rd("baud2_rst", 3'd7, 8'h01, lat);

    // THR write stalls on full FIFO
    tx_fifo_full = 1;
    fork
      wr(3'd0, 8'hA5);
      begin
        repeat (5) @(posedge clk);
        check_val("thr_no_push_full", wr_cnt, 0);
        #1 tx_fifo_full = 0;
      end
    join
    check_val("thr_push_cnt", wr_cnt, 1);
    check_val("thr_push_data", 32'(wr_data), 32'hA5);
    check_val("thr_ready_after_push", rdy_cyc - wr_cyc, 1);

    // RBR pop with read latency 2
    rx_fifo_empty = 0; data_to_reg = 8'h3C;
    rd("rbr_data", 3'd0, 8'h3C, lat);
    check_val("rbr_latency", lat, 4);
    check_val("rbr_pop_cnt", rd_cnt, 1);
    rx_fifo_empty = 1;
    rd("rbr_empty", 3'd0, 8'h00, lat);
    check_val("rbr_empty_latency", lat, 1);
    check_val("rbr_empty_no_pop", rd_cnt, 1);

    // staged baud commit waits for idle transceiver
    tx_work = 1;
    wr(3'd5, 8'h80); wr(3'd6, 8'h25); wr(3'd7, 8'h00);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("baud_held_busy", 32'(uart_buad), 32'd115200);
    rd("baud1_shadow", 3'd6, 8'h25, lat);
    @(posedge clk); #1 tx_work = 0;
    @(negedge clk);
    check_val("baud_before_edge", 32'(uart_buad), 32'd115200);
    @(negedge clk);
    check_val("baud_committed", 32'(uart_buad), 32'd9600);
    wr(3'd3, 8'h57);
    repeat (2) @(negedge clk);
    check_val("lcr_commit", 32'({st_check, parity, check, data_length}), 32'h57);
    rd("lcr_shadow", 3'd3, 8'h57, lat);

    // interrupt priority and LSR error ack
    p_error = 1; rx_fifo_empty = 0;
    wr(3'd1, 8'h07);
    rd("iir_err", 3'd2, 8'h06, lat);
    rd("lsr_err", 3'd4, 8'h13, lat);
    @(negedge clk);
    check_val("p_ack_cnt", pack_cnt, 1);
    check_val("st_ack_cnt", sack_cnt, 0);
    p_error = 0;
    rd("iir_rx", 3'd2, 8'h04, lat);
    rx_fifo_empty = 1;
    rd("iir_tx", 3'd2, 8'h02, lat);
    rd("iir_none", 3'd2, 8'h01, lat);

    // tx-empty interrupt
    wr(3'd1, 8'h02);
    wait_irq("irq_low_no_flag", 1'b0);
    tx_work = 1;
    repeat (2) @(posedge clk);
    #1 tx_work = 0;
    wait_irq("irq_tx_idle", 1'b1);
    rd("iir_tx2", 3'd2, 8'h02, lat);
    repeat (2) @(negedge clk);
    check_val("irq_cleared", 32'(irq), 32'd0);
    tx_fifo_cnt = 1;
    wr(3'd0, 8'h11);
    repeat (2) @(negedge clk);
    check_val("irq_low_after_thr", 32'(irq), 32'd0);
    check_val("thr2_data", 32'(wr_data), 32'h11);
    tx_fifo_cnt = 0;
    wait_irq("irq_reraise", 1'b1);

    // reset mid-access drops ready and pending commit
    tx_work = 1;
    wr(3'd7, 8'h03);
    rx_fifo_empty = 0;
    @(posedge clk); #1;
    bus.cs = 1; bus.we = 0; bus.addr = 3'd0;
    repeat (2) @(posedge clk);
    #1 rstn = 0;
    #1 check_val("rst_mid_ready", 32'(bus.ready), 32'd0);
    bus.cs = 0;
    @(posedge clk); #1 rstn = 1; tx_work = 0;
    repeat (3) @(negedge clk);
    check_val("rst_mid_baud", 32'(uart_buad), 32'd115200);
    check_val("rst_mid_irq", 32'(irq), 32'd0);
    rx_fifo_empty = 1;
    rd("baud2_after_rst", 3'd7, 8'h01, lat);
    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
